// File: rtl/ieee754_pkg.sv
`default_nettype none
// ============================================================================
// Module : ieee754_pkg
// Brief  : Shared IEEE-754 single-precision helpers for the argmax reducer.
// Rev    : 1.0  initial release
// ============================================================================
package ieee754_pkg;

    localparam logic [31:0] FP_QNAN     = 32'h7FC0_0000;
    localparam logic [7:0]  FP_EXP_ALL1 = 8'hFF;

    typedef enum logic [1:0] {
        FIRST = 2'd0,
        ACC   = 2'd1,
        DONE  = 2'd2
    } state_t;

    function automatic logic is_nan(input logic [31:0] x);
        return (x[30:23] == FP_EXP_ALL1) && (x[22:0] != 23'd0);
    endfunction

    // Monotonic unsigned key: -0 sorts just below +0, negatives invert fully.
    function automatic logic [31:0] fp_order_key(input logic [31:0] x);
        return x[31] ? ~x : {1'b1, x[30:0]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/ieee754_order_key.sv
`default_nettype none
// ============================================================================
// Module : ieee754_order_key
// Brief  : Combinational ordering key and NaN flag for one IEEE-754 single.
// Rev    : 1.0  initial release
// ============================================================================
module ieee754_order_key
    import ieee754_pkg::*;
(
    input  logic [31:0] i_data,
    output logic [31:0] o_key,
    output logic        o_is_nan
);

    assign o_key    = fp_order_key(i_data);
    assign o_is_nan = is_nan(i_data);

endmodule
`default_nettype wire

// File: rtl/ieee754_stream_argmax.sv
`default_nettype none
// ============================================================================
// Module : ieee754_stream_argmax
// Brief  : Streaming max/min reducer returning extreme value, index, count.
// Rev    : 1.0  initial release
// ============================================================================
module ieee754_stream_argmax
    import ieee754_pkg::*;
#(
    parameter int IDX_W    = 16,
    parameter bit MODE_MIN = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [31:0]      s_data,
    input  logic             s_last,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [31:0]      m_value,
    output logic [IDX_W-1:0] m_idx,
    output logic [IDX_W-1:0] m_count,
    output logic             m_nan_seen,
    output logic             m_sat
);

    state_t             r_state;
    state_t             w_state_nxt;

    logic [31:0]        r_cur;
    logic [31:0]        r_cur_key;
    logic [IDX_W-1:0]   r_cur_idx;
    logic [IDX_W-1:0]   r_cnt;
    logic               r_valid_cur;
    logic               r_nan;
    logic               r_sat;

    logic [31:0]        w_key;
    logic               w_is_nan;
    logic               w_beat;
    logic               w_win;
    logic               w_take;
    logic               w_cnt_full;
    logic [IDX_W-1:0]   w_cnt_nxt;
    logic               w_all_nan;

    ieee754_order_key u_key (
        .i_data   (s_data),
        .o_key    (w_key),
        .o_is_nan (w_is_nan)
    );

    // Strict comparison so ties keep the earliest index.
    generate
        if (MODE_MIN) begin : g_min
            assign w_win = (w_key < r_cur_key);
        end else begin : g_max
            assign w_win = (w_key > r_cur_key);
        end
    endgenerate

    assign w_beat     = s_valid && s_ready;
    assign w_take     = !w_is_nan && (!r_valid_cur || w_win);
    assign w_cnt_full = &r_cnt;
    assign w_cnt_nxt  = w_cnt_full ? r_cnt : r_cnt + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= FIRST;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        s_ready     = 1'b0;
        m_valid     = 1'b0;
        case (r_state)
            FIRST, ACC: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    w_state_nxt = s_last ? DONE : ACC;
                end
            end
            DONE: begin
                m_valid = 1'b1;
                if (m_ready) begin
                    w_state_nxt = FIRST;
                end
            end
            default: w_state_nxt = FIRST;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cur       <= '0;
            r_cur_key   <= '0;
            r_cur_idx   <= '0;
            r_cnt       <= '0;
            r_valid_cur <= 1'b0;
            r_nan       <= 1'b0;
            r_sat       <= 1'b0;
        end else if (w_beat) begin
            if (r_state == FIRST) begin
                r_cur       <= s_data;
                r_cur_key   <= w_key;
                r_cur_idx   <= '0;
                r_cnt       <= '0;
                r_valid_cur <= !w_is_nan;
                r_nan       <= w_is_nan;
                r_sat       <= 1'b0;
            end else begin
                r_cnt <= w_cnt_nxt;
                r_nan <= r_nan | w_is_nan;
                if (w_cnt_full) begin
                    r_sat <= 1'b1;
                end
                if (w_take) begin
                    r_cur       <= s_data;
                    r_cur_key   <= w_key;
                    r_cur_idx   <= w_cnt_nxt;
                    r_valid_cur <= 1'b1;
                end
            end
        end else if (m_valid && m_ready) begin
            r_valid_cur <= 1'b0;
            r_nan       <= 1'b0;
            r_sat       <= 1'b0;
        end
    end

    // An all-NaN packet reports a canonical quiet NaN at index 0.
    assign w_all_nan  = (r_state == DONE) && !r_valid_cur;
    assign m_value    = w_all_nan ? FP_QNAN : r_cur;
    assign m_idx      = w_all_nan ? '0 : r_cur_idx;
    assign m_count    = r_cnt;
    assign m_nan_seen = r_nan;
    assign m_sat      = r_sat;

endmodule
`default_nettype wire

// File: tb/tb_ieee754_stream_argmax.sv
`default_nettype none
// ============================================================================
// Module : tb_ieee754_stream_argmax
// Brief  : Directed vector bench; a max instance and a narrow min instance.
// Rev    : 1.0  initial release
// ============================================================================
module tb_ieee754_stream_argmax;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        s_valid = 1'b0;
    logic [31:0] s_data = '0;
    logic        s_last = 1'b0;
    logic        m_ready = 1'b0;

    logic        x_s_ready, x_m_valid, x_nan, x_sat;
    logic [31:0] x_value;
    logic [15:0] x_idx, x_count;
    logic        n_s_ready, n_m_valid, n_nan, n_sat;
    logic [31:0] n_value;
    logic [1:0]  n_idx, n_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ieee754_stream_argmax #(.IDX_W(16), .MODE_MIN(1'b0)) u_max (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(x_s_ready),
        .s_data(s_data), .s_last(s_last), .m_valid(x_m_valid), .m_ready(m_ready),
        .m_value(x_value), .m_idx(x_idx), .m_count(x_count),
        .m_nan_seen(x_nan), .m_sat(x_sat)
    );

    ieee754_stream_argmax #(.IDX_W(2), .MODE_MIN(1'b1)) u_min (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(n_s_ready),
        .s_data(s_data), .s_last(s_last), .m_valid(n_m_valid), .m_ready(m_ready),
        .m_value(n_value), .m_idx(n_idx), .m_count(n_count),
        .m_nan_seen(n_nan), .m_sat(n_sat)
    );

    typedef struct packed {
        logic [31:0]      n;
        logic [5:0][31:0] d;
        logic [31:0]      xv, xi, xc;
        logic             xs;
        logic [31:0]      nv, ni, nc;
        logic             ns;
        logic             nan;
    } vec_t;

    vec_t vecs [7];

    function automatic vec_t mk(input int n,
                                input logic [31:0] a0, a1, a2, a3, a4, a5,
                                input logic [31:0] xv, input int xi, xc, input bit xs,
                                input logic [31:0] nv, input int ni, nc, input bit ns,
                                input bit nan);
        vec_t r;
        r.n = n;
        r.d[0] = a0; r.d[1] = a1; r.d[2] = a2; r.d[3] = a3; r.d[4] = a4; r.d[5] = a5;
        r.xv = xv; r.xi = xi; r.xc = xc; r.xs = xs;
        r.nv = nv; r.ni = ni; r.nc = nc; r.ns = ns;
        r.nan = nan;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input vec_t v, input bit last_on_end);
        for (int b = 0; b < int'(v.n); b++) begin
            s_valid = 1'b1;
            s_data  = v.d[b];
            s_last  = last_on_end && (b == int'(v.n) - 1);
            tick();
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic wait_result(input string nm);
        int k;
        k = 0;
        while (!(x_m_valid && n_m_valid) && k < 10) begin
            tick();
            k++;
        end
        if (!(x_m_valid && n_m_valid)) begin
            total++;
            bad++;
            $display("FAIL %s timeout: m_valid max=%b min=%b want 1", nm, x_m_valid, n_m_valid);
        end
    endtask

    task automatic accept(input string nm);
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        chk({nm, " bubble m_valid"}, {31'd0, x_m_valid}, 32'd0);
        chk({nm, " bubble s_ready"}, {31'd0, x_s_ready}, 32'd1);
        chk({nm, " min bubble s_ready"}, {31'd0, n_s_ready}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] held_v;
        logic [15:0] held_i;
        vec_t rv;

        //            n  beats                                                                      max: value idx cnt sat  min: value idx cnt sat  nan
        vecs[0] = mk(4, 32'h3F800000, 32'hC0000000, 32'h40400000, 32'h40000000, 0, 0, 32'h40400000, 2, 3, 0, 32'hC0000000, 1, 3, 0, 0);
        vecs[1] = mk(3, 32'h80000000, 32'h00000000, 32'h00000000, 0, 0, 0,          32'h00000000, 1, 2, 0, 32'h80000000, 0, 2, 0, 0);
        vecs[2] = mk(2, 32'h7FC00001, 32'hBF800000, 0, 0, 0, 0,                    32'hBF800000, 1, 1, 0, 32'hBF800000, 1, 1, 0, 1);
        vecs[3] = mk(1, 32'h7F800001, 0, 0, 0, 0, 0,                               32'h7FC00000, 0, 0, 0, 32'h7FC00000, 0, 0, 0, 1);
        vecs[4] = mk(6, 32'h40000000, 32'h3F800000, 32'h40400000, 32'h40800000, 32'hBF800000, 32'hC0400000,
                                                                                     32'h40800000, 3, 5, 0, 32'hC0400000, 3, 3, 1, 0);
        vecs[5] = mk(4, 32'h00000001, 32'h7F800000, 32'hFF800000, 32'h00000002, 0, 0, 32'h7F800000, 1, 3, 0, 32'hFF800000, 2, 3, 0, 0);
        vecs[6] = mk(3, 32'hC0000000, 32'hBF800000, 32'hC0000000, 0, 0, 0,          32'hBF800000, 1, 2, 0, 32'hC0000000, 0, 2, 0, 0);

        #12;
        chk("reset m_value", x_value, 32'd0);
        chk("reset m_idx", {16'd0, x_idx}, 32'd0);
        chk("reset m_count", {16'd0, x_count}, 32'd0);
        chk("reset flags", {28'd0, x_m_valid, x_nan, x_sat, x_s_ready}, 32'd1);
        chk("reset min m_value", n_value, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 7; i++) begin
            string p;
            p = $sformatf("v%0d", i);
            chk({p, " s_ready before"}, {31'd0, x_s_ready}, 32'd1);
            send(vecs[i], 1'b1);
            chk({p, " latency m_valid"}, {30'd0, x_m_valid, n_m_valid}, 32'd3);
            wait_result(p);
            chk({p, " max value"}, x_value, vecs[i].xv);
            chk({p, " max idx"}, {16'd0, x_idx}, vecs[i].xi);
            chk({p, " max count"}, {16'd0, x_count}, vecs[i].xc);
            chk({p, " max sat"}, {31'd0, x_sat}, {31'd0, vecs[i].xs});
            chk({p, " max nan"}, {31'd0, x_nan}, {31'd0, vecs[i].nan});
            chk({p, " min value"}, n_value, vecs[i].nv);
            chk({p, " min idx"}, {30'd0, n_idx}, vecs[i].ni);
            chk({p, " min count"}, {30'd0, n_count}, vecs[i].nc);
            chk({p, " min sat"}, {31'd0, n_sat}, {31'd0, vecs[i].ns});
            chk({p, " min nan"}, {31'd0, n_nan}, {31'd0, vecs[i].nan});
            accept(p);
        end

        // Backpressure: result held, upstream beats ignored while in DONE.
        send(vecs[0], 1'b1);
        wait_result("bp");
        held_v = x_value;
        held_i = x_idx;
        chk("bp value", held_v, 32'h40400000);
        for (int c = 0; c < 5; c++) begin
            s_valid = 1'b1;
            s_data  = 32'h7F7FFFFF;
            s_last  = 1'b1;
            tick();
            chk($sformatf("bp c%0d value", c), x_value, held_v);
            chk($sformatf("bp c%0d idx", c), {16'd0, x_idx}, {16'd0, held_i});
            chk($sformatf("bp c%0d ready/valid", c), {30'd0, x_s_ready, x_m_valid}, 32'd1);
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        chk("bp count", {16'd0, x_count}, 32'd3);
        accept("bp");

        // Reset in the middle of a packet discards it.
        rv = mk(2, 32'h7FC00001, 32'h3F800000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        send(rv, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst value", x_value, 32'd0);
        chk("midrst idx/count", {x_idx, x_count}, 32'd0);
        chk("midrst flags", {28'd0, x_m_valid, x_nan, x_sat, x_s_ready}, 32'd1);
        chk("midrst min flags", {28'd0, n_m_valid, n_nan, n_sat, n_s_ready}, 32'd1);
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        rv = mk(1, 32'h41200000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        send(rv, 1'b1);
        wait_result("postrst");
        chk("postrst value", x_value, 32'h41200000);
        chk("postrst idx", {16'd0, x_idx}, 32'd0);
        chk("postrst count", {16'd0, x_count}, 32'd0);
        chk("postrst nan", {31'd0, x_nan}, 32'd0);
        chk("postrst min value", n_value, 32'h41200000);
        accept("postrst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
